// File: rtl/hawk_pkg.sv
// Shared types for the sector read sequencer: FSM state encoding and the
// completion status codes reported on the status port.
package hawk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SYNC,
        DATA,
        CHECK,
        FINISH
    } state_t;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_TIMEOUT  = 2'd1;
    localparam logic [1:0] ST_OVERRUN  = 2'd2;
    localparam logic [1:0] ST_CHECKSUM = 2'd3;

    // States in which the separator runs and the bit-cell watchdog is armed.
    function automatic logic is_active(input state_t s);
        return s inside {PREAMBLE, SYNC, DATA, CHECK};
    endfunction

endpackage

// File: rtl/word_deserializer.sv
// MSB-first shift register with bit counter; flags the cycle in which the
// final bit of a word arrives and presents the assembled word combinationally.
module word_deserializer #(
    parameter int WORD_BITS = 16
) (
    input  logic                 hf_clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 shift_en,
    input  logic                 bit_data,
    output logic                 word_done,
    output logic [WORD_BITS-1:0] word
);

    localparam int CW = $clog2(WORD_BITS + 1);

    // Only the leading WORD_BITS-1 bits need storage; the last arrives live.
    logic [WORD_BITS-2:0] shreg;
    logic [CW-1:0]        bit_cnt;

    assign word      = {shreg, bit_data};
    assign word_done = shift_en && (bit_cnt == CW'(WORD_BITS - 1));

    always_ff @(posedge hf_clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shreg   <= word[WORD_BITS-2:0];
            bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sector_read_sequencer.sv
// Sector read sequencer: hunts preamble and sync, deserializes a sector of
// words to a valid/ready consumer, and verifies the trailing XOR checkword.
module sector_read_sequencer
    import hawk_pkg::*;
#(
    parameter int WORD_BITS     = 16,
    parameter int SECTOR_WORDS  = 128,
    parameter int PREAMBLE_MIN  = 32,
    parameter int TIMEOUT_TICKS = 200
) (
    input  logic                 hf_clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 bit_clock,
    input  logic                 bit_data,
    output logic                 sep_en,
    output logic [WORD_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           status
);

    localparam int ZW = $clog2(PREAMBLE_MIN + 1);
    localparam int WW = $clog2(SECTOR_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    state_t               state, state_nxt;
    logic [ZW-1:0]        zero_cnt;
    logic [WW-1:0]        word_cnt;
    logic [TW-1:0]        tick_cnt;
    logic [WORD_BITS-1:0] checksum;
    logic [WORD_BITS-1:0] word;
    logic                 word_done;
    logic                 accept, timed_out, data_word, overrun, load_word;

    word_deserializer #(.WORD_BITS(WORD_BITS)) u_deser (
        .hf_clk    (hf_clk),
        .rst       (rst),
        .clr       (accept),
        .shift_en  (bit_clock && (state == DATA || state == CHECK)),
        .bit_data  (bit_data),
        .word_done (word_done),
        .word      (word)
    );

    assign accept    = (state == IDLE) && start && !abort;
    assign timed_out = is_active(state) && !bit_clock && (tick_cnt == TW'(TIMEOUT_TICKS));
    assign data_word = (state == DATA) && word_done;
    assign overrun   = data_word && out_valid && !out_ready;
    assign load_word = data_word && !overrun;

    assign sep_en = is_active(state);
    assign busy   = (state != IDLE);
    assign done   = (state == FINISH);

    always_ff @(posedge hf_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (start) state_nxt = PREAMBLE;
                PREAMBLE: if (timed_out) state_nxt = FINISH;
                          else if (bit_clock && !bit_data && zero_cnt == ZW'(PREAMBLE_MIN - 1))
                              state_nxt = SYNC;
                SYNC:     if (timed_out) state_nxt = FINISH;
                          else if (bit_clock && bit_data) state_nxt = DATA;
                DATA:     if (timed_out || overrun) state_nxt = FINISH;
                          else if (data_word && word_cnt == WW'(SECTOR_WORDS - 1))
                              state_nxt = CHECK;
                CHECK:    if (timed_out || word_done) state_nxt = FINISH;
                FINISH:   state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge hf_clk or posedge rst) begin
        if (rst) begin
            zero_cnt  <= '0;
            word_cnt  <= '0;
            tick_cnt  <= '0;
            checksum  <= '0;
            status    <= ST_OK;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (accept) begin
                zero_cnt <= '0;
                word_cnt <= '0;
                tick_cnt <= '0;
                checksum <= '0;
                status   <= ST_OK;
            end else begin
                // Watchdog saturates at the limit; leaving the active states resets it.
                if (bit_clock || !is_active(state))
                    tick_cnt <= '0;
                else if (tick_cnt != TW'(TIMEOUT_TICKS))
                    tick_cnt <= tick_cnt + TW'(1);

                if (state == PREAMBLE && bit_clock) begin
                    if (bit_data)
                        zero_cnt <= '0;
                    else if (zero_cnt != ZW'(PREAMBLE_MIN))
                        zero_cnt <= zero_cnt + ZW'(1);
                end

                if (load_word) begin
                    word_cnt <= word_cnt + WW'(1);
                    checksum <= checksum ^ word;
                end

                // Abort leaves the previous outcome visible.
                if (!abort) begin
                    if (timed_out)
                        status <= ST_TIMEOUT;
                    else if (overrun)
                        status <= ST_OVERRUN;
                    else if (state == CHECK && word_done)
                        status <= (word == checksum) ? ST_OK : ST_CHECKSUM;
                end
            end

            // A fresh word wins over a same-cycle consume, keeping valid high.
            if (abort)
                out_valid <= 1'b0;
            else if (load_word) begin
                out_data  <= word;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule
